serial_divider: RTL and testbench

//   Multi-cycle unsigned integer divider producing one quotient bit per clock (restoring division).

---
 rtl/serial_divider.sv | 104 ++++++++++
 tb/tb_serial_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// Restoring serial divider. It produces one quotient bit per clock, MSB first.
// The quotient register is updated only at completion and holds its value until the next result.
module serial_divider #(
  parameter int DIVIDEND_WIDTH = 18,
  parameter int DIVISOR_WIDTH  = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      divide_cmd_i,
  input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
  input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
  output logic [DIVIDEND_WIDTH-1:0] quotient_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int CW = $clog2(DIVIDEND_WIDTH + 1);
  localparam int RW = DIVISOR_WIDTH + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [DIVIDEND_WIDTH-1:0] r_dividend;
  logic [DIVIDEND_WIDTH-1:0] r_quot_shift;
  logic [DIVIDEND_WIDTH-1:0] r_quotient;
  logic [DIVISOR_WIDTH-1:0]  r_divisor;
  logic [RW-1:0]             r_rem;
  logic [CW-1:0]             r_count;
  logic                      r_done;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_qbit;
  logic [RW-1:0]             w_rem_shift;
  logic [RW-1:0]             w_rem_next;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (divide_cmd_i) begin
          w_accept     = 1'b1;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_count == CW'(1)) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The remainder always stays below the divisor, so dropping its top bit on the shift loses nothing.
  assign w_rem_shift = {r_rem[RW-2:0], r_dividend[DIVIDEND_WIDTH-1]};
  assign w_qbit      = (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_next  = w_qbit ? (w_rem_shift - {1'b0, r_divisor}) : w_rem_shift;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_rem        <= '0;
      r_count      <= '0;
      r_quot_shift <= '0;
      r_quotient   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_dividend   <= dividend_i;
        r_divisor    <= divisor_i;
        r_rem        <= '0;
        r_count      <= CW'(DIVIDEND_WIDTH);
        r_quot_shift <= '0;
      end else if (r_state == S_BUSY) begin
        r_dividend   <= r_dividend << 1;
        r_rem        <= w_rem_next;
        r_quot_shift <= {r_quot_shift[DIVIDEND_WIDTH-2:0], w_qbit};
        r_count      <= r_count - CW'(1);
        if (w_last) begin
          r_quotient <= {r_quot_shift[DIVIDEND_WIDTH-2:0], w_qbit};
        end
      end
    end
  end

  assign quotient_o = r_quotient;
  assign busy_o     = (r_state == S_BUSY);
  assign done_o     = r_done;

endmodule

// File: tb/tb_serial_divider.sv
// Scoreboard bench for serial_divider: a stimulus process queues the expected quotient and accept cycle.
// A monitor pops and checks the queue on each done pulse, and checks that the quotient holds between results.
module tb_serial_divider;

  localparam int DW = 18;
  localparam int VW = 12;
  localparam int LAT = DW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          divide_cmd_i = 1'b0;
  logic [DW-1:0] dividend_i = '0;
  logic [VW-1:0] divisor_i = '0;
  logic [DW-1:0] quotient_o;
  logic          busy_o;
  logic          done_o;

  serial_divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .divide_cmd_i (divide_cmd_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .quotient_o   (quotient_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] q;
    int            acc;
    int            dvd;
    int            dvs;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [DW-1:0] last_q = '0;

  always @(posedge clk_i) cyc++;

  function automatic logic [DW-1:0] ref_div(input int a, input int b);
    if (b == 0) return DW'((1 << DW) - 1);
    return DW'(a / b);
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", quotient_o, e.q);
          check("latency", cyc - e.acc, LAT);
          check("busy_in_done", busy_o, 0);
          $display("div %0d / %0d -> q=%0d (exp %0d) at cycle %0d", e.dvd, e.dvs, quotient_o, e.q, cyc);
        end
        last_q = quotient_o;
      end else if (quotient_o != last_q) begin
        check("quotient_hold", quotient_o, last_q);
      end
    end else begin
      last_q = '0;
    end
  end

  // Called right after a falling edge; waits for idle, then presents one command for one cycle.
  task automatic issue(input int a, input int b);
    int n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o) check("wait_idle_timeout", 1, 0);
    dividend_i   = DW'(a);
    divisor_i    = VW'(b);
    divide_cmd_i = 1'b1;
    sb.push_back('{q: ref_div(a, b), acc: cyc + 1, dvd: a, dvs: b});
    @(negedge clk_i);
    divide_cmd_i = 1'b0;
    check("busy_after_accept", busy_o, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk_i);
    while (!done_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!done_o) check("done_timeout", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    @(negedge clk_i);
  endtask

  initial begin
    int a;
    int b;
    int mode;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_quotient", quotient_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);

    // Directed: reference values for the 2^17 reciprocal use case and boundary operands.
    issue(131072, 1080);
    drain();
    issue(131072, 2160);
    drain();
    issue(131072, 4095);
    drain();
    issue(131072, 1);
    drain();
    issue(1000, 480);
    drain();
    issue(599, 600);
    drain();
    issue(131072, 0);
    drain();
    issue(262143, 4095);
    drain();

    // A command with new operands while busy must be ignored.
    issue(131072, 1080);
    repeat (5) @(negedge clk_i);
    dividend_i   = 18'd5000;
    divisor_i    = 12'd7;
    divide_cmd_i = 1'b1;
    @(negedge clk_i);
    divide_cmd_i = 1'b0;
    drain();

    // Back-to-back: a command in the done cycle is accepted.
    issue(131072, 1080);
    wait_done();
    issue(131072, 2160);
    drain();

    // Async reset mid-division aborts the division without a done pulse.
    issue(131072, 1080);
    repeat (7) @(negedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    check("async_rst_quotient", quotient_o, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_done", done_o, 0);
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (25) @(negedge clk_i);
    issue(131072, 2160);
    drain();

    // Random traffic: mixed gaps, back-to-back commands, ignored mid-run commands.
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 9));
      a = (mode < 2) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, (1 << DW) - 1));
      if (mode == 0) b = 0;
      else if (mode == 3) b = int'($urandom_range(1, 15));
      else b = int'($urandom_range(1, (1 << VW) - 1));
      if (busy_o && $urandom_range(0, 1) == 1) wait_done();
      issue(a, b);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 10)) @(negedge clk_i);
        dividend_i   = DW'($urandom);
        divisor_i    = VW'($urandom);
        divide_cmd_i = 1'b1;
        @(negedge clk_i);
        divide_cmd_i = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 25)) @(negedge clk_i);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
